// File: rtl/fifo_sync_param_if.sv
// Write/read handshake bundle for fifo_sync_param.
// The overflow, underflow and err_clr members exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
`else
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, empty, full, almost_empty, almost_full, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, empty, full, almost_empty, almost_full, count
  );
`endif
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with threshold flags and either a registered or first-word-fall-through read.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags cleared by err_clr.
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  fifo_sync_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  // Acceptance looks only at registered occupancy, so a full FIFO rejects a write even when
  // a read is popping in the same cycle, and an empty FIFO never writes through to a read.
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_wr_acc = bus.wr_en && !w_full && !rst;
  assign w_rd_acc = bus.rd_en && !w_empty && !rst;

  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (r_count >= CW'(AF_THRESH));
  assign bus.almost_empty = (r_count <= CW'(AE_THRESH));
  assign bus.count        = r_count;

  // Storage is never reset so it maps onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head entry is shown asynchronously; zero while empty keeps the post-reset value clean.
      assign bus.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
      assign bus.rd_valid = !w_empty;
    end else begin : g_reg_read
      logic [WIDTH-1:0] r_rd_data;
      logic             r_rd_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
          end
        end
      end

      assign bus.rd_data  = r_rd_data;
      assign bus.rd_valid = r_rd_valid;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error in the same cycle as err_clr must not be lost, so setting has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_overflow <= 1'b0;
      end
      if (bus.rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif
endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=4.
REQ-003 Parameter AF_THRESH, default DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  WIDTH  write data, sampled with an accepted write.
REQ-010 rd_en  input  1  read (FWFT: pop) request.
REQ-011 rd_data  output  WIDTH  read data.
REQ-012 rd_valid  output  1  rd_data qualifier.
REQ-013 empty / full  output  1 each  count==0 / count==DEPTH.
REQ-014 almost_empty / almost_full  output  1 each  threshold flags per REQ-003/004.
REQ-015 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky error flags (only with FIFO_ERR_FLAGS_EN).
REQ-017 err_clr  input  1  clears sticky error flags (only with FIFO_ERR_FLAGS_EN).

Function
REQ-018 Write accepted iff wr_en && !full, full evaluated on pre-edge state; accepted word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 Read accepted iff rd_en && !empty, pre-edge state; rd_ptr increments modulo DEPTH.
REQ-020 count next = count + accepted_write - accepted_read; simultaneous accepted write and read leave count unchanged.
REQ-021 Full with wr_en && rd_en: read accepted, write rejected; count becomes DEPTH-1.
REQ-022 Empty with wr_en && rd_en: write accepted, read rejected; count becomes 1 (no write-through).
REQ-023 Flags empty, full, almost_empty, almost_full derive combinationally from registered count only; no flag depends on wr_en/rd_en in the same cycle.
REQ-024 FWFT=0: on an accepted read, rd_data registers the head entry and rd_valid pulses high for exactly the following cycle; rd_data holds its last value otherwise; latency rd_en to data = 1 cycle.
REQ-025 FWFT=1: rd_data presents the head entry whenever !empty; rd_valid = !empty; accepted read advances head visible next cycle; rd_data undefined-but-stable value is not required while empty.
REQ-026 Write-to-empty visibility: FWFT=1 rd_valid rises 1 cycle after the accepted write; FWFT=0 first readable via rd_en in that same following cycle.
REQ-027 Pointers wrap seamlessly; data order preserved across any number of wraps.

Reset
REQ-028 rst sampled high at clk edge: count=0, wr_ptr=rd_ptr=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=underflow=0.
REQ-029 wr_en/rd_en ignored in any cycle where rst is high; reset mid-operation discards all stored entries; memory array is not cleared.

Configuration
REQ-030 Macro FIFO_ERR_FLAGS_EN defined: overflow sets on wr_en && full, underflow sets on rd_en && empty; both sticky until err_clr; set and err_clr in same cycle: set wins.
REQ-031 Macro FIFO_ERR_FLAGS_EN undefined: overflow, underflow, err_clr ports absent; rejected requests dropped silently; all other behaviour identical.

Verification
REQ-032 Defaults, FWFT=0: 17 single-cycle writes of 0x01..0x11 -> full=1 after 16th, count=16, 17th dropped, overflow=1 (macro on); then 17 reads -> 0x01..0x10 in order, rd_valid 16 pulses, underflow=1 on 17th.
REQ-033 Thresholds: write 14 words -> almost_full rises the cycle count reaches 14; read down -> almost_empty rises when count reaches 2.
REQ-034 Simultaneous ops: at count=16 assert wr_en&&rd_en -> count=15, written word absent; at count=0 -> count=1, rd_valid stays 0.
REQ-035 FWFT=1: write 0xA5 into empty -> next cycle rd_valid=1, rd_data=0xA5 without rd_en; pop -> rd_valid=0.
REQ-036 Wrap and reset: stream 40 words with concurrent reads at count~8 -> order intact; assert rst at count=5 -> next cycle count=0, empty=1, rd_valid=0, flags cleared.
